rob_retire_buffer: RTL and testbench

- 16-entry reorder buffer for the out-of-order core.
- Rename/dispatch writes one row per cycle and gets back its ROB number; that number is what reservation-station rows carry.
- The three functional units mark rows complete by ROB number.
- The block retires the oldest completed row in program order, one per cycle. For each retire it reports the committed destination preg, and returns the old preg to the free list.

---
 rtl/rob_retire_buffer_pkg.sv | 25 ++
 rtl/rob_retire_buffer.sv | 178 +++++++++++++++++
 tb/tb_rob_retire_buffer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_retire_buffer_pkg.sv
// Types and constants shared by the reorder buffer.
//   ROB_DEPTH / ROB_IDX_W : number of rows and width of a ROB number
//   NUM_FU                : number of completion ports
//   p_reg                 : physical register address
//   rob_idx               : ROB row number
//   rob_row_struct        : one ROB row (status bits plus payload)
package rob_retire_buffer_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_IDX_W = 4;
   localparam int NUM_FU    = 3;
   localparam int PREG_W    = 7;

   typedef logic [PREG_W-1:0]    p_reg;
   typedef logic [ROB_IDX_W-1:0] rob_idx;

   typedef struct packed {
      logic valid;
      logic complete;
      p_reg PRegAddrDst;
      p_reg OldPRegAddrDst;
      logic RegWrite;
   } rob_row_struct;

endpackage

// File: rtl/rob_retire_buffer.sv
// 16-entry reorder buffer: in-order dispatch, out-of-order completion,
// in-order retire of at most one row per cycle.
// Ports:
//   clk, reset (async, active high), flush (sync squash of all rows)
//   disp_*   : dispatch request with new/old preg and RegWrite; disp_ready,
//              disp_rob_num report space and the row a dispatch receives
//   cmpl_*   : per-FU completion strobe and ROB number
//   retire_* : registered retire pulse with row number and committed preg
//   free_*   : registered old-preg release towards the free list
//   count, empty : occupancy
module rob_retire_buffer
   import rob_retire_buffer_pkg::*;
#(
   parameter int DEPTH  = rob_retire_buffer_pkg::ROB_DEPTH,
   parameter int IDX_W  = rob_retire_buffer_pkg::ROB_IDX_W,
   parameter int NUM_FU = rob_retire_buffer_pkg::NUM_FU
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    disp_valid,
   input  logic [6:0]              disp_PRegAddrDst,
   input  logic [6:0]              disp_OldPRegAddrDst,
   input  logic                    disp_RegWrite,
   output logic                    disp_ready,
   output logic [IDX_W-1:0]        disp_rob_num,
   input  logic [NUM_FU-1:0]       cmpl_valid,
   input  logic [NUM_FU*IDX_W-1:0] cmpl_rob_num,
   output logic                    retire_valid,
   output logic [IDX_W-1:0]        retire_rob_num,
   output logic [6:0]              retire_PRegAddrDst,
   output logic                    free_valid,
   output logic [6:0]              free_preg,
   output logic [IDX_W:0]          count,
   output logic                    empty
);

   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W:0]   CNT_ZERO = {(IDX_W+1){1'b0}};
   localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);

   rob_row_struct    rows_r     [DEPTH];
   rob_row_struct    rows_nxt_s [DEPTH];
   logic [IDX_W-1:0] head_r, head_nxt_s;
   logic [IDX_W-1:0] tail_r, tail_nxt_s;
   logic [IDX_W:0]   count_r, count_nxt_s;

   logic             retire_valid_r, retire_valid_nxt_s;
   logic [IDX_W-1:0] retire_rob_num_r, retire_rob_num_nxt_s;
   p_reg             retire_dst_r, retire_dst_nxt_s;
   logic             free_valid_r, free_valid_nxt_s;
   p_reg             free_preg_r, free_preg_nxt_s;

   logic             disp_accept_s;
   logic             retire_s;
   logic [IDX_W-1:0] cmpl_idx_s [NUM_FU];

   // Dispatch acceptance uses the registered count only, so a retire in the
   // same cycle never frees a slot for a same-cycle dispatch.
   always_comb begin
      disp_accept_s = disp_valid && (count_r != CNT_FULL);
      retire_s      = rows_r[head_r].valid && rows_r[head_r].complete;
   end

   // Slice the packed completion bus into one ROB number per FU.
   always_comb begin
      for (int k = 0; k < NUM_FU; k++) begin
         cmpl_idx_s[k] = cmpl_rob_num[k*IDX_W +: IDX_W];
      end
   end

   // Next-state for rows, pointers, count and retire outputs. Order inside
   // the non-flush branch matters: completion, then dispatch write, then
   // retire clear, so a completion racing the head retire cannot revive it.
   always_comb begin
      rows_nxt_s           = rows_r;
      head_nxt_s           = head_r;
      tail_nxt_s           = tail_r;
      count_nxt_s          = count_r;
      retire_valid_nxt_s   = 1'b0;
      free_valid_nxt_s     = 1'b0;
      retire_rob_num_nxt_s = retire_rob_num_r;
      retire_dst_nxt_s     = retire_dst_r;
      free_preg_nxt_s      = free_preg_r;

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            rows_nxt_s[i].valid    = 1'b0;
            rows_nxt_s[i].complete = 1'b0;
         end
         head_nxt_s  = IDX_ZERO;
         tail_nxt_s  = IDX_ZERO;
         count_nxt_s = CNT_ZERO;
      end else begin
         // Completions to rows that are not valid are dropped.
         for (int k = 0; k < NUM_FU; k++) begin
            if (cmpl_valid[k] && rows_r[cmpl_idx_s[k]].valid) begin
               rows_nxt_s[cmpl_idx_s[k]].complete = 1'b1;
            end else begin
               rows_nxt_s[cmpl_idx_s[k]].complete = rows_nxt_s[cmpl_idx_s[k]].complete;
            end
         end

         if (disp_accept_s) begin
            rows_nxt_s[tail_r].valid          = 1'b1;
            rows_nxt_s[tail_r].complete       = 1'b0;
            rows_nxt_s[tail_r].PRegAddrDst    = disp_PRegAddrDst;
            rows_nxt_s[tail_r].OldPRegAddrDst = disp_OldPRegAddrDst;
            rows_nxt_s[tail_r].RegWrite       = disp_RegWrite;
            tail_nxt_s                        = tail_r + IDX_ONE;
         end else begin
            tail_nxt_s = tail_r;
         end

         if (retire_s) begin
            retire_valid_nxt_s          = 1'b1;
            free_valid_nxt_s            = rows_r[head_r].RegWrite;
            retire_rob_num_nxt_s        = head_r;
            retire_dst_nxt_s            = rows_r[head_r].PRegAddrDst;
            free_preg_nxt_s             = rows_r[head_r].OldPRegAddrDst;
            rows_nxt_s[head_r].valid    = 1'b0;
            rows_nxt_s[head_r].complete = 1'b0;
            head_nxt_s                  = head_r + IDX_ONE;
         end else begin
            head_nxt_s = head_r;
         end

         case ({disp_accept_s, retire_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rows_r[i] <= '0;
         end
         head_r           <= IDX_ZERO;
         tail_r           <= IDX_ZERO;
         count_r          <= CNT_ZERO;
         retire_valid_r   <= 1'b0;
         free_valid_r     <= 1'b0;
         retire_rob_num_r <= IDX_ZERO;
         retire_dst_r     <= 7'd0;
         free_preg_r      <= 7'd0;
      end else begin
         rows_r           <= rows_nxt_s;
         head_r           <= head_nxt_s;
         tail_r           <= tail_nxt_s;
         count_r          <= count_nxt_s;
         retire_valid_r   <= retire_valid_nxt_s;
         free_valid_r     <= free_valid_nxt_s;
         retire_rob_num_r <= retire_rob_num_nxt_s;
         retire_dst_r     <= retire_dst_nxt_s;
         free_preg_r      <= free_preg_nxt_s;
      end
   end

   // Output drive: registered state plus occupancy-derived flags.
   always_comb begin
      retire_valid       = retire_valid_r;
      retire_rob_num     = retire_rob_num_r;
      retire_PRegAddrDst = retire_dst_r;
      free_valid         = free_valid_r;
      free_preg          = free_preg_r;
      count              = count_r;
      empty              = (count_r == CNT_ZERO);
      disp_ready         = (count_r != CNT_FULL);
      disp_rob_num       = tail_r;
   end

endmodule

// File: tb/tb_rob_retire_buffer.sv
// Self-checking bench for rob_retire_buffer. Dispatched rows are pushed to
// an expected-retire queue; a negedge monitor pops and compares each retire.
module tb_rob_retire_buffer;

   typedef struct packed {
      logic [3:0] num;
      logic [6:0] dst;
      logic       rw;
      logic [6:0] old;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        disp_valid = 1'b0;
   logic [6:0]  disp_PRegAddrDst = 7'd0;
   logic [6:0]  disp_OldPRegAddrDst = 7'd0;
   logic        disp_RegWrite = 1'b0;
   logic        disp_ready;
   logic [3:0]  disp_rob_num;
   logic [2:0]  cmpl_valid = 3'd0;
   logic [11:0] cmpl_rob_num = 12'd0;
   logic        retire_valid;
   logic [3:0]  retire_rob_num;
   logic [6:0]  retire_PRegAddrDst;
   logic        free_valid;
   logic [6:0]  free_preg;
   logic [4:0]  count;
   logic        empty;

   int   checks = 0;
   int   errors = 0;
   int   retire_cnt = 0;
   exp_t exp_q[$];

   rob_retire_buffer dut (
      .clk                 (clk),
      .reset               (reset),
      .flush               (flush),
      .disp_valid          (disp_valid),
      .disp_PRegAddrDst    (disp_PRegAddrDst),
      .disp_OldPRegAddrDst (disp_OldPRegAddrDst),
      .disp_RegWrite       (disp_RegWrite),
      .disp_ready          (disp_ready),
      .disp_rob_num        (disp_rob_num),
      .cmpl_valid          (cmpl_valid),
      .cmpl_rob_num        (cmpl_rob_num),
      .retire_valid        (retire_valid),
      .retire_rob_num      (retire_rob_num),
      .retire_PRegAddrDst  (retire_PRegAddrDst),
      .free_valid          (free_valid),
      .free_preg           (free_preg),
      .count               (count),
      .empty               (empty)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic dispatch(input logic [6:0] dst, input logic [6:0] old, input logic rw);
      exp_t e;
      disp_valid          = 1'b1;
      disp_PRegAddrDst    = dst;
      disp_OldPRegAddrDst = old;
      disp_RegWrite       = rw;
      if (disp_ready) begin
         e.num = disp_rob_num;
         e.dst = dst;
         e.rw  = rw;
         e.old = old;
         exp_q.push_back(e);
      end
      tick();
      disp_valid = 1'b0;
   endtask

   task automatic complete(input logic [2:0] v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      cmpl_valid   = v;
      cmpl_rob_num = {c, b, a};
      tick();
      cmpl_valid = 3'd0;
   endtask

   task automatic wait_retires(input int target);
      int n = 0;
      while (retire_cnt < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_value("wait_retire", retire_cnt, target);
   endtask

   // Scoreboard monitor: every retire pulse must match the oldest dispatch.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && retire_valid) begin
         if (exp_q.size() == 0) begin
            check_value("retire_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_value("sb_rob_num", retire_rob_num, e.num);
            check_value("sb_dst", retire_PRegAddrDst, e.dst);
            check_value("sb_free_valid", free_valid, e.rw);
            check_value("sb_free_preg", free_preg, e.old);
         end
         retire_cnt++;
      end
   end

   initial begin
      int base;
      int found;

      // Reset state held for 10 cycles with no traffic.
      do_reset();
      repeat (10) begin
         @(negedge clk);
         check_value("rst_disp_ready", disp_ready, 1);
         check_value("rst_disp_rob_num", disp_rob_num, 0);
         check_value("rst_empty", empty, 1);
         check_value("rst_retire_valid", retire_valid, 0);
      end

      // Out-of-order completion, in-order retire.
      dispatch(7'd40, 7'd5, 1'b1);
      dispatch(7'd41, 7'd6, 1'b1);
      dispatch(7'd42, 7'd7, 1'b1);
      @(negedge clk);
      check_value("ooo_count", count, 3);
      complete(3'b010, 4'd0, 4'd1, 4'd0);
      @(negedge clk);
      check_value("ooo_no_retire", retire_valid, 0);
      complete(3'b101, 4'd0, 4'd0, 4'd2);
      @(negedge clk);
      check_value("ooo_latency", retire_valid, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_value("ooo_b2b_valid", retire_valid, 1);
         check_value("ooo_b2b_num", retire_rob_num, i);
      end
      @(negedge clk);
      check_value("ooo_done_valid", retire_valid, 0);
      check_value("ooo_empty", empty, 1);

      // Full buffer, ignored 17th dispatch, wrap-around.
      do_reset();
      base = retire_cnt;
      for (int i = 0; i < 16; i++) dispatch(7'(50 + i), 7'(i), 1'b1);
      @(negedge clk);
      check_value("full_count", count, 16);
      check_value("full_ready", disp_ready, 0);
      dispatch(7'd99, 7'd99, 1'b1);
      @(negedge clk);
      check_value("full_ignored_count", count, 16);
      check_value("full_ignored_tail", disp_rob_num, 0);
      complete(3'b001, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      check_value("full_lat_valid", retire_valid, 0);
      check_value("full_lat_ready", disp_ready, 0);
      @(negedge clk);
      check_value("full_ret_valid", retire_valid, 1);
      check_value("full_ret_num", retire_rob_num, 0);
      check_value("full_ready_after", disp_ready, 1);
      check_value("full_count_after", count, 15);
      check_value("wrap_rob_num", disp_rob_num, 0);
      dispatch(7'd90, 7'd30, 1'b1);
      for (int i = 1; i < 16; i++) complete(3'b001, 4'(i), 4'd0, 4'd0);
      complete(3'b001, 4'd0, 4'd0, 4'd0);
      wait_retires(base + 17);
      @(negedge clk);
      check_value("full_drained", empty, 1);

      // Completion to an empty row is ignored; the row later needs its own.
      do_reset();
      base = retire_cnt;
      complete(3'b010, 4'd0, 4'd5, 4'd0);
      repeat (3) begin
         @(negedge clk);
         check_value("ghost_retire", retire_valid, 0);
         check_value("ghost_count", count, 0);
      end
      for (int i = 0; i < 6; i++) dispatch(7'(100 + i), 7'(40 + i), 1'b1);
      complete(3'b111, 4'd0, 4'd1, 4'd2);
      complete(3'b011, 4'd3, 4'd4, 4'd0);
      wait_retires(base + 5);
      repeat (4) begin
         @(negedge clk);
         check_value("row5_stalled", retire_valid, 0);
      end
      check_value("row5_count", count, 1);
      complete(3'b100, 4'd0, 4'd0, 4'd5);
      wait_retires(base + 6);

      // Store row: retires without releasing a preg.
      check_value("store_rob_num", disp_rob_num, 6);
      dispatch(7'd60, 7'd9, 1'b0);
      complete(3'b001, 4'd6, 4'd0, 4'd0);
      found = 0;
      for (int n = 0; n < 10 && found == 0; n++) begin
         @(negedge clk);
         if (retire_valid) found = 1;
      end
      check_value("store_retired", found, 1);
      check_value("store_free_valid", free_valid, 0);
      check_value("store_free_preg", free_preg, 9);

      // Flush beats a same-cycle dispatch and completion.
      do_reset();
      for (int i = 0; i < 4; i++) dispatch(7'(110 + i), 7'(60 + i), 1'b1);
      complete(3'b011, 4'd2, 4'd3, 4'd0);
      flush               = 1'b1;
      disp_valid          = 1'b1;
      disp_PRegAddrDst    = 7'd120;
      disp_OldPRegAddrDst = 7'd70;
      cmpl_valid          = 3'b001;
      cmpl_rob_num        = 12'd0;
      tick();
      flush      = 1'b0;
      disp_valid = 1'b0;
      cmpl_valid = 3'd0;
      exp_q.delete();
      repeat (2) begin
         @(negedge clk);
         check_value("flush_retire", retire_valid, 0);
         check_value("flush_count", count, 0);
      end
      check_value("flush_rob_num", disp_rob_num, 0);
      base = retire_cnt;
      dispatch(7'd121, 7'd71, 1'b1);
      complete(3'b001, 4'd0, 4'd0, 4'd0);
      wait_retires(base + 1);

      // Async reset in the middle of a retire burst.
      do_reset();
      for (int i = 0; i < 3; i++) dispatch(7'(80 + i), 7'(20 + i), 1'b1);
      complete(3'b111, 4'd0, 4'd1, 4'd2);
      found = 0;
      for (int n = 0; n < 10 && found == 0; n++) begin
         @(negedge clk);
         if (retire_valid) found = 1;
      end
      check_value("burst_started", found, 1);
      #1 reset = 1'b1;
      exp_q.delete();
      #1;
      check_value("arst_retire_valid", retire_valid, 0);
      check_value("arst_free_valid", free_valid, 0);
      check_value("arst_rob_num", retire_rob_num, 0);
      check_value("arst_dst", retire_PRegAddrDst, 0);
      check_value("arst_free_preg", free_preg, 0);
      check_value("arst_count", count, 0);
      check_value("arst_ready", disp_ready, 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
